// File: rtl/bus_trace_pkg.sv
// Shared types for the Z80 bus tracer: cycle classes, sequencer states, record layout.
// Also provides the strobe classifier used on the captured bus samples.
package bus_trace_pkg;

    typedef enum logic [2:0] {
        CYC_FETCH  = 3'd0,
        CYC_MEM_RD = 3'd1,
        CYC_MEM_WR = 3'd2,
        CYC_IO_RD  = 3'd3,
        CYC_IO_WR  = 3'd4,
        CYC_INTA   = 3'd5,
        CYC_NONE   = 3'd7
    } cyc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_TYPE,
        ST_AHI,
        ST_ALO,
        ST_DATA
    } state_t;

    typedef struct packed {
        cyc_t        typ;
        logic [15:0] addr;
        logic [7:0]  data;
    } trace_rec_t;

    typedef struct packed {
        logic        m1_n;
        logic        mreq_n;
        logic        iorq_n;
        logic        rd_n;
        logic        wr_n;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_smp_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam bus_smp_t BUS_IDLE = '{m1_n: 1'b1, mreq_n: 1'b1, iorq_n: 1'b1,
                                      rd_n: 1'b1, wr_n: 1'b1, addr: 16'h0000, data: 8'h00};

    // Strobes are active-low; earlier tests win.
    function automatic cyc_t classify(input bus_smp_t b);
        cyc_t c;
        c = CYC_NONE;
        if (!b.m1_n && !b.mreq_n && !b.rd_n) c = CYC_FETCH;
        else if (!b.m1_n && !b.iorq_n)       c = CYC_INTA;
        else if (!b.mreq_n && !b.rd_n)       c = CYC_MEM_RD;
        else if (!b.mreq_n && !b.wr_n)       c = CYC_MEM_WR;
        else if (!b.iorq_n && !b.rd_n)       c = CYC_IO_RD;
        else if (!b.iorq_n && !b.wr_n)       c = CYC_IO_WR;
        return c;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO holding whole trace records; head is always visible on head_dat.
// Latency: push visible at head one edge later. Backpressure: push while full is ignored unless a pop occurs the same edge.
// Pop while empty is ignored; reset clears pointers and count.
module trace_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     CLK_n,
    input  logic                     RESET_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge CLK_n) begin
        if (!RESET_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge CLK_n) begin
        if (RESET_n && do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/bus_trace_sequencer.sv
// Captures completed Z80 bus cycles as {type,A,D} records and serialises them as 5-byte frames.
// Latency: cycle end sampled at edge k -> FIFO write k+1 -> SYNC byte valid after k+2.
// Backpressure: tx_valid/tx_ready hold each byte; records arriving with the FIFO full are dropped and counted.
module bus_trace_sequencer
    import bus_trace_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic        CLK_n,
    input  logic        RESET_n,
    input  logic        M1_n,
    input  logic        MREQ_n,
    input  logic        IORQ_n,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic        trace_en,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        overflow,
    output logic [7:0]  dropped_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bus_smp_t   s1_q;
    bus_smp_t   s2_q;
    cyc_t       cls1;
    cyc_t       cls2;
    logic       end_evt;
    logic       push;
    logic       pop;
    logic       drop;
    trace_rec_t push_rec;
    trace_rec_t head_rec;
    logic       fifo_full;
    logic       fifo_empty;
    logic [CW-1:0] fifo_cnt;
    state_t     state_q;
    state_t     state_d;

    always_ff @(posedge CLK_n) begin
        if (!RESET_n) begin
            s1_q <= BUS_IDLE;
            s2_q <= BUS_IDLE;
        end else begin
            s1_q <= '{m1_n: M1_n, mreq_n: MREQ_n, iorq_n: IORQ_n,
                      rd_n: RD_n, wr_n: WR_n, addr: A, data: D};
            s2_q <= s1_q;
        end
    end

    // A cycle has ended once the newer sample no longer shows the same class.
    assign cls1     = classify(s1_q);
    assign cls2     = classify(s2_q);
    assign end_evt  = (cls2 != CYC_NONE) && (cls1 != cls2);
    assign push     = end_evt && trace_en;
    assign push_rec = '{typ: cls2, addr: s2_q.addr, data: s2_q.data};
    assign drop     = push && fifo_full && !pop;

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(trace_rec_t))
    ) u_fifo (
        .CLK_n    (CLK_n),
        .RESET_n  (RESET_n),
        .push     (push),
        .push_dat (push_rec),
        .pop      (pop),
        .head_dat (head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_ff @(posedge CLK_n) begin
        if (!RESET_n) begin
            overflow    <= 1'b0;
            dropped_cnt <= 8'h00;
        end else if (drop) begin
            overflow <= 1'b1;
            if (dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 8'h01;
        end
    end

    always_ff @(posedge CLK_n) begin
        if (!RESET_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Every byte of a frame reads the FIFO head; the entry is only released with the DATA byte.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        case (state_q)
            ST_IDLE: begin
                tx_valid = 1'b0;
                if (!fifo_empty) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                tx_data = SYNC_BYTE;
                if (tx_ready) state_d = ST_TYPE;
            end
            ST_TYPE: begin
                tx_data = {5'b00000, head_rec.typ};
                if (tx_ready) state_d = ST_AHI;
            end
            ST_AHI: begin
                tx_data = head_rec.addr[15:8];
                if (tx_ready) state_d = ST_ALO;
            end
            ST_ALO: begin
                tx_data = head_rec.addr[7:0];
                if (tx_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_data = head_rec.data;
                if (tx_ready) begin
                    pop     = 1'b1;
                    state_d = (fifo_cnt > CW'(1)) ? ST_SYNC : ST_IDLE;
                end
            end
            default: begin
                tx_valid = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_trace_sequencer.sv
// Directed bench for bus_trace_sequencer: drives Z80 strobe patterns and checks emitted frames byte by byte.
module tb_bus_trace_sequencer;

    logic        CLK_n;
    logic        RESET_n;
    logic        M1_n, MREQ_n, IORQ_n, RD_n, WR_n;
    logic [15:0] A;
    logic [7:0]  D;
    logic        trace_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        overflow;
    logic [7:0]  dropped_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // {M1_n, MREQ_n, IORQ_n, RD_n, WR_n}
    localparam logic [4:0] B_IDLE  = 5'b11111;
    localparam logic [4:0] B_FETCH = 5'b00101;
    localparam logic [4:0] B_MRD   = 5'b10101;
    localparam logic [4:0] B_MWR   = 5'b10110;
    localparam logic [4:0] B_IORD  = 5'b11001;
    localparam logic [4:0] B_IOWR  = 5'b11010;
    localparam logic [4:0] B_INTA  = 5'b01011;

    bus_trace_sequencer #(.FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
        .CLK_n       (CLK_n),
        .RESET_n     (RESET_n),
        .M1_n        (M1_n),
        .MREQ_n      (MREQ_n),
        .IORQ_n      (IORQ_n),
        .RD_n        (RD_n),
        .WR_n        (WR_n),
        .A           (A),
        .D           (D),
        .trace_en    (trace_en),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .overflow    (overflow),
        .dropped_cnt (dropped_cnt)
    );

    initial CLK_n = 1'b0;
    always #5 CLK_n = ~CLK_n;

    task automatic tick;
        @(posedge CLK_n);
        #1;
    endtask

    task automatic bus_set(input logic [4:0] s, input logic [15:0] a, input logic [7:0] d);
        {M1_n, MREQ_n, IORQ_n, RD_n, WR_n} = s;
        A = a;
        D = d;
    endtask

    // Hold a bus cycle for n edges, then release the strobes; the next edge samples them inactive.
    task automatic bus_cycle(input logic [4:0] s, input logic [15:0] a, input logic [7:0] d, input int n);
        bus_set(s, a, d);
        repeat (n) tick();
        bus_set(B_IDLE, 16'h0000, 8'h00);
    endtask

    task automatic test_reset;
        RESET_n = 1'b0;
        repeat (3) tick();
        n_tests++; if (tx_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_valid: got %b want 0", tx_valid); end
        n_tests++; if (tx_data !== 8'h00)     begin n_fail++; $display("FAIL rst_data: got %h want 00", tx_data); end
        n_tests++; if (overflow !== 1'b0)     begin n_fail++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        n_tests++; if (dropped_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_drop: got %h want 00", dropped_cnt); end
        RESET_n = 1'b1;
        repeat (3) tick();
        n_tests++; if (tx_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_release_valid: got %b want 0", tx_valid); end
    endtask

    task automatic test_mem_write;
        logic [7:0] exp [5] = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h5A};
        tx_ready = 1'b1;
        bus_cycle(B_MWR, 16'h1234, 8'h5A, 3);
        tick();  // edge k: strobes first sampled inactive
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL memwr_lat_k: got %b want 0", tx_valid); end
        tick();  // edge k+1: FIFO write
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL memwr_lat_k1: got %b want 0", tx_valid); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if ({tx_valid, tx_data} !== {1'b1, exp[i]}) begin
                n_fail++; $display("FAIL memwr_byte%0d: got v=%b %h want v=1 %h", i, tx_valid, tx_data, exp[i]);
            end
        end
        tick();
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL memwr_after: got %b want 0", tx_valid); end
        repeat (4) tick();
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL memwr_no_dup: got %b want 0", tx_valid); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [10] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'hC3,
                                 8'hA5, 8'h01, 8'h00, 8'h01, 8'h00};
        int w;
        tx_ready = 1'b1;
        bus_set(B_FETCH, 16'h0000, 8'hC3);
        repeat (2) tick();
        bus_cycle(B_MRD, 16'h0001, 8'h00, 2);
        w = 0;
        while (!tx_valid && w < 20) begin tick(); w++; end
        n_tests++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout: got %b want 1", tx_valid); end
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if ({tx_valid, tx_data} !== {1'b1, exp[i]}) begin
                n_fail++; $display("FAIL b2b_byte%0d: got v=%b %h want v=1 %h", i, tx_valid, tx_data, exp[i]);
            end
            tick();
        end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_after: got %b want 0", tx_valid); end
    endtask

    task automatic test_overflow;
        logic [7:0] e;
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus_cycle(B_IOWR, 16'(16'h0010 + i), 8'(8'h30 + i), 2);
            tick();
        end
        repeat (3) tick();
        n_tests++; if (overflow !== 1'b1)     begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_tests++; if (dropped_cnt !== 8'd2)  begin n_fail++; $display("FAIL ovf_cnt: got %0d want 2", dropped_cnt); end
        n_tests++; if ({tx_valid, tx_data} !== {1'b1, 8'hA5}) begin
            n_fail++; $display("FAIL ovf_stall: got v=%b %h want v=1 a5", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 5; j++) begin
                case (j)
                    0:       e = 8'hA5;
                    1:       e = 8'h04;
                    2:       e = 8'h00;
                    3:       e = 8'(8'h10 + r);
                    default: e = 8'(8'h30 + r);
                endcase
                n_tests++;
                if ({tx_valid, tx_data} !== {1'b1, e}) begin
                    n_fail++; $display("FAIL ovf_rec%0d_byte%0d: got v=%b %h want v=1 %h", r, j, tx_valid, tx_data, e);
                end
                tick();
            end
        end
        n_tests++; if (tx_valid !== 1'b0)    begin n_fail++; $display("FAIL ovf_drained: got %b want 0", tx_valid); end
        n_tests++; if (dropped_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_cnt_hold: got %0d want 2", dropped_cnt); end
    endtask

    task automatic test_handshake;
        logic [7:0] exp [5] = '{8'hA5, 8'h02, 8'hBE, 8'hEF, 8'h77};
        int         idx;
        logic       prev_stall;
        logic [7:0] prev_dat;
        tx_ready = 1'b0;
        bus_cycle(B_MWR, 16'hBEEF, 8'h77, 2);
        idx = 0;
        prev_stall = 1'b0;
        prev_dat = 8'h00;
        for (int i = 0; i < 40; i++) begin
            tx_ready = i[0];
            if (prev_stall) begin
                n_tests++;
                if ({tx_valid, tx_data} !== {1'b1, prev_dat}) begin
                    n_fail++; $display("FAIL hs_hold%0d: got v=%b %h want v=1 %h", i, tx_valid, tx_data, prev_dat);
                end
            end
            if (tx_valid && tx_ready) begin
                if (idx < 5) begin
                    n_tests++;
                    if (tx_data !== exp[idx]) begin
                        n_fail++; $display("FAIL hs_byte%0d: got %h want %h", idx, tx_data, exp[idx]);
                    end
                end
                idx++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_dat = tx_data;
            tick();
        end
        n_tests++; if (idx != 5)          begin n_fail++; $display("FAIL hs_count: got %0d want 5", idx); end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL hs_after: got %b want 0", tx_valid); end
        tx_ready = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp [5] = '{8'hA5, 8'h03, 8'h00, 8'hFE, 8'h42};
        int   w;
        logic seen;
        tx_ready = 1'b1;
        bus_cycle(B_IOWR, 16'h2233, 8'h44, 2);
        w = 0;
        while (!tx_valid && w < 20) begin tick(); w++; end
        tick();
        tick();
        n_tests++; if (tx_data !== 8'h22) begin n_fail++; $display("FAIL rmid_ahi: got %h want 22", tx_data); end
        RESET_n = 1'b0;
        tick();
        n_tests++; if (tx_valid !== 1'b0)     begin n_fail++; $display("FAIL rmid_valid: got %b want 0", tx_valid); end
        n_tests++; if (tx_data !== 8'h00)     begin n_fail++; $display("FAIL rmid_data: got %h want 00", tx_data); end
        n_tests++; if (overflow !== 1'b0)     begin n_fail++; $display("FAIL rmid_ovf: got %b want 0", overflow); end
        n_tests++; if (dropped_cnt !== 8'h00) begin n_fail++; $display("FAIL rmid_drop: got %h want 00", dropped_cnt); end
        RESET_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin tick(); if (tx_valid) seen = 1'b1; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_empty: got %b want 0", seen); end
        bus_cycle(B_IORD, 16'h00FE, 8'h42, 2);
        w = 0;
        while (!tx_valid && w < 20) begin tick(); w++; end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({tx_valid, tx_data} !== {1'b1, exp[i]}) begin
                n_fail++; $display("FAIL rmid_byte%0d: got v=%b %h want v=1 %h", i, tx_valid, tx_data, exp[i]);
            end
            tick();
        end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got %b want 0", tx_valid); end
    endtask

    task automatic test_inta;
        logic [7:0] exp [5] = '{8'hA5, 8'h05, 8'h00, 8'h38, 8'hFF};
        int   w;
        logic seen;
        tx_ready = 1'b1;
        trace_en = 1'b1;
        bus_cycle(B_INTA, 16'h0038, 8'hFF, 2);
        w = 0;
        while (!tx_valid && w < 20) begin tick(); w++; end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({tx_valid, tx_data} !== {1'b1, exp[i]}) begin
                n_fail++; $display("FAIL inta_byte%0d: got v=%b %h want v=1 %h", i, tx_valid, tx_data, exp[i]);
            end
            tick();
        end
        trace_en = 1'b0;
        bus_cycle(B_INTA, 16'h0038, 8'hFF, 2);
        seen = 1'b0;
        repeat (12) begin tick(); if (tx_valid) seen = 1'b1; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL inta_disabled: got %b want 0", seen); end
        trace_en = 1'b1;
    endtask

    initial begin
        RESET_n  = 1'b0;
        trace_en = 1'b1;
        tx_ready = 1'b0;
        bus_set(B_IDLE, 16'h0000, 8'h00);
        test_reset();
        test_mem_write();
        test_back_to_back();
        test_overflow();
        test_handshake();
        test_reset_mid();
        test_inta();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
